// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - Hack CPU instruction-fetch responder with optional sequential prefetch
//
// Optional feature macro: INSTR_FETCH_PREFETCH_EN (one-entry sequential prefetch buffer)
// Parameter : TIMEOUT      cycles to wait for mem_ack before aborting a read (1..65535)
// Ports     : clk, reset_n (sync, active-low)
//             pc_addr, fetch_req             fetch request from the PC
//             instr, instr_valid, stall      delivery to the CPU / PC hold
//             mem_addr, mem_rd               registered read request to memory
//             mem_rdata, mem_ack             read response from memory
//             timeout_err                    sticky read-timeout flag
module instr_fetch #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] pc_addr,
  input  logic        fetch_req,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic [14:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

`ifdef INSTR_FETCH_PREFETCH_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PREFETCH} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        stall_q, stall_d;
  logic [14:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] cnt_q, cnt_d;

`ifdef INSTR_FETCH_PREFETCH_EN
  logic        buf_valid_q, buf_valid_d;
  logic [14:0] buf_tag_q, buf_tag_d;
  logic [15:0] buf_data_q, buf_data_d;
  logic [14:0] pf_addr_q, pf_addr_d;     // address the next/current prefetch reads
  logic        pend_q, pend_d;           // non-matching request waiting on the prefetch
  logic [14:0] pend_addr_q, pend_addr_d;
`endif

  logic ack;
  logic tmo;
  logic req;

  // Acks only count while a read is actually on the bus, so a held or late
  // ack after mem_rd drops is never taken.
  assign ack = mem_rd_q & mem_ack;
  assign tmo = mem_rd_q & ~mem_ack & (cnt_q == TO_LAST);
  assign req = fetch_req & ~stall_q;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    stall_d       = stall_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_d      = mem_rd_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = mem_rd_q ? cnt_q + 16'd1 : 16'd0;
`ifdef INSTR_FETCH_PREFETCH_EN
    buf_valid_d   = buf_valid_q;
    buf_tag_d     = buf_tag_q;
    buf_data_d    = buf_data_q;
    pf_addr_d     = pf_addr_q;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
`ifdef INSTR_FETCH_PREFETCH_EN
          if (buf_valid_q && (pc_addr == buf_tag_q)) begin
            instr_d       = buf_data_q;
            instr_valid_d = 1'b1;
            pf_addr_d     = buf_tag_q + 15'd1;
            state_d       = S_PREFETCH;
          end else begin
`endif
            mem_addr_d = pc_addr;
            mem_rd_d   = 1'b1;
            stall_d    = 1'b1;
            state_d    = S_FETCH;
`ifdef INSTR_FETCH_PREFETCH_EN
          end
`endif
        end
      end

      S_FETCH: begin
        if (!mem_rd_q) begin
          // Entered from a prefetch handoff with mem_rd low; issue the read now.
          mem_rd_d = 1'b1;
        end else if (ack) begin
          mem_rd_d      = 1'b0;
          instr_d       = mem_rdata;
          instr_valid_d = 1'b1;
          stall_d       = 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
          pf_addr_d     = mem_addr_q + 15'd1;
          state_d       = S_PREFETCH;
`else
          state_d       = S_IDLE;
`endif
        end else if (tmo) begin
          mem_rd_d      = 1'b0;
          instr_d       = 16'h0000;
          instr_valid_d = 1'b1;
          stall_d       = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end
      end

`ifdef INSTR_FETCH_PREFETCH_EN
      S_PREFETCH: begin
        if (!mem_rd_q) begin
          // Launch cycle: mem_rd stayed low for a cycle after the previous read.
          mem_addr_d = pf_addr_q;
          mem_rd_d   = 1'b1;
          if (req) begin
            stall_d = 1'b1;
            if (pc_addr == pf_addr_q) begin
              state_d = S_FETCH;
            end else begin
              pend_d      = 1'b1;
              pend_addr_d = pc_addr;
            end
          end
        end else if (ack) begin
          mem_rd_d    = 1'b0;
          buf_valid_d = 1'b1;
          buf_tag_d   = mem_addr_q;
          buf_data_d  = mem_rdata;
          if (pend_q) begin
            pend_d     = 1'b0;
            mem_addr_d = pend_addr_q;
            state_d    = S_FETCH;
          end else if (req) begin
            if (pc_addr == mem_addr_q) begin
              instr_d       = mem_rdata;
              instr_valid_d = 1'b1;
              pf_addr_d     = mem_addr_q + 15'd1;
            end else begin
              mem_addr_d = pc_addr;
              stall_d    = 1'b1;
              state_d    = S_FETCH;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else if (tmo) begin
          mem_rd_d      = 1'b0;
          timeout_err_d = 1'b1;
          buf_valid_d   = 1'b0;
          pend_d        = 1'b0;
          stall_d       = 1'b0;
          state_d       = S_IDLE;
        end else if (req) begin
          stall_d = 1'b1;
          if (pc_addr == mem_addr_q) begin
            // Same read already in flight; promote it to a demand fetch.
            state_d = S_FETCH;
          end else begin
            pend_d      = 1'b1;
            pend_addr_d = pc_addr;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      instr_q       <= 16'h0000;
      instr_valid_q <= 1'b0;
      stall_q       <= 1'b0;
      mem_addr_q    <= 15'h0000;
      mem_rd_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= 16'd0;
`ifdef INSTR_FETCH_PREFETCH_EN
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= 15'h0000;
      buf_data_q    <= 16'h0000;
      pf_addr_q     <= 15'h0000;
      pend_q        <= 1'b0;
      pend_addr_q   <= 15'h0000;
`endif
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      stall_q       <= stall_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
`ifdef INSTR_FETCH_PREFETCH_EN
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_data_q    <= buf_data_d;
      pf_addr_q     <= pf_addr_d;
      pend_q        <= pend_d;
      pend_addr_q   <= pend_addr_d;
`endif
    end
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign stall       = stall_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (TIMEOUT = 4)
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] pc_addr;
  logic        fetch_req;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic [14:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_addr    (pc_addr),
    .fetch_req  (fetch_req),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [14:0] addr;
    logic        ack;
    logic [15:0] rdata;
    logic        e_valid;
    logic [15:0] e_instr;
    logic        e_stall;
    logic        e_rd;
    logic [14:0] e_addr;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the rising edge.
  task automatic step(input logic req, input logic [14:0] addr, input logic ack, input logic [15:0] rdata);
    @(negedge clk);
    fetch_req = req;
    pc_addr   = addr;
    mem_ack   = ack;
    mem_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag, input logic v, input logic [15:0] ins, input logic st,
                     input logic rd, input logic [14:0] ad, input logic te);
    chk({tag, ".valid"}, 16'(instr_valid), 16'(v));
    chk({tag, ".instr"}, instr, ins);
    chk({tag, ".stall"}, 16'(stall), 16'(st));
    chk({tag, ".mem_rd"}, 16'(mem_rd), 16'(rd));
    chk({tag, ".mem_addr"}, {1'b0, mem_addr}, {1'b0, ad});
    chk({tag, ".terr"}, 16'(timeout_err), 16'(te));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b0, 15'h0, 1'b0, 16'h0);
    reset_n = 1'b1;
  endtask

  vec_t vecs[12];

  initial begin
    reset_n   = 1'b0;
    fetch_req = 1'b0;
    pc_addr   = 15'h0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    step(1'b0, 15'h0, 1'b0, 16'h0);
    step(1'b0, 15'h0, 1'b0, 16'h0);
    out("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 15'h0000, 1'b0);
    reset_n = 1'b1;

`ifndef INSTR_FETCH_PREFETCH_EN
    //           req  addr      ack  rdata     vld  instr     stl  rd   addr
    vecs[0]  = '{1'b1, 15'h0005, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 15'h0005};
    vecs[1]  = '{1'b0, 15'h0000, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0, 15'h0005};
    vecs[2]  = '{1'b0, 15'h0000, 1'b1, 16'hFFFF, 1'b0, 16'h1234, 1'b0, 1'b0, 15'h0005};
    vecs[3]  = '{1'b1, 15'h0040, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b1, 15'h0040};
    vecs[4]  = '{1'b1, 15'h0300, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b1, 15'h0040};
    vecs[5]  = '{1'b0, 15'h0000, 1'b1, 16'hABCD, 1'b1, 16'hABCD, 1'b0, 1'b0, 15'h0040};
    vecs[6]  = '{1'b0, 15'h0000, 1'b0, 16'h0000, 1'b0, 16'hABCD, 1'b0, 1'b0, 15'h0040};
    vecs[7]  = '{1'b1, 15'h7FFF, 1'b0, 16'h0000, 1'b0, 16'hABCD, 1'b1, 1'b1, 15'h7FFF};
    vecs[8]  = '{1'b0, 15'h0000, 1'b1, 16'h5A5A, 1'b1, 16'h5A5A, 1'b0, 1'b0, 15'h7FFF};
    vecs[9]  = '{1'b1, 15'h0000, 1'b0, 16'h0000, 1'b0, 16'h5A5A, 1'b1, 1'b1, 15'h0000};
    vecs[10] = '{1'b0, 15'h0000, 1'b1, 16'h0F0F, 1'b1, 16'h0F0F, 1'b0, 1'b0, 15'h0000};
    vecs[11] = '{1'b0, 15'h0000, 1'b0, 16'h0000, 1'b0, 16'h0F0F, 1'b0, 1'b0, 15'h0000};
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].req, vecs[i].addr, vecs[i].ack, vecs[i].rdata);
      out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_stall,
          vecs[i].e_rd, vecs[i].e_addr, 1'b0);
    end
`endif

    // Timeout: mem_rd high for exactly 4 cycles, then a zero delivery.
    do_reset();
    step(1'b1, 15'h0123, 1'b0, 16'h0);
    out("to_c1", 1'b0, 16'h0000, 1'b1, 1'b1, 15'h0123, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      step(1'b0, 15'h0, 1'b0, 16'h0);
      out($sformatf("to_c%0d", k), 1'b0, 16'h0000, 1'b1, 1'b1, 15'h0123, 1'b0);
    end
    step(1'b0, 15'h0, 1'b0, 16'h0);
    out("to_dlv", 1'b1, 16'h0000, 1'b0, 1'b0, 15'h0123, 1'b1);
    step(1'b0, 15'h0, 1'b1, 16'hBEEF);
    out("to_late", 1'b0, 16'h0000, 1'b0, 1'b0, 15'h0123, 1'b1);
    step(1'b1, 15'h0055, 1'b0, 16'h0);
    out("sticky_req", 1'b0, 16'h0000, 1'b1, 1'b1, 15'h0055, 1'b1);
    step(1'b0, 15'h0, 1'b1, 16'h9999);
    out("sticky_dlv", 1'b1, 16'h9999, 1'b0, 1'b0, 15'h0055, 1'b1);
`ifdef INSTR_FETCH_PREFETCH_EN
    step(1'b0, 15'h0, 1'b0, 16'h0);
    step(1'b0, 15'h0, 1'b1, 16'h0);
`endif

    // Reset mid-FETCH aborts the read; a later ack is never delivered.
    step(1'b1, 15'h0010, 1'b0, 16'h0);
    out("rf_req", 1'b0, 16'h9999, 1'b1, 1'b1, 15'h0010, 1'b1);
    step(1'b0, 15'h0, 1'b0, 16'h0);
    out("rf_wait", 1'b0, 16'h9999, 1'b1, 1'b1, 15'h0010, 1'b1);
    reset_n = 1'b0;
    step(1'b0, 15'h0, 1'b0, 16'h0);
    out("rf_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 15'h0000, 1'b0);
    reset_n = 1'b1;
    step(1'b0, 15'h0, 1'b1, 16'hBEEF);
    out("rf_late1", 1'b0, 16'h0000, 1'b0, 1'b0, 15'h0000, 1'b0);
    step(1'b0, 15'h0, 1'b1, 16'hBEEF);
    out("rf_late2", 1'b0, 16'h0000, 1'b0, 1'b0, 15'h0000, 1'b0);

`ifdef INSTR_FETCH_PREFETCH_EN
    // Wrap: 7FFF prefetches 0000, which then hits.
    step(1'b1, 15'h7FFF, 1'b0, 16'h0);
    out("wr_req", 1'b0, 16'h0000, 1'b1, 1'b1, 15'h7FFF, 1'b0);
    step(1'b0, 15'h0, 1'b1, 16'h1111);
    out("wr_dlv", 1'b1, 16'h1111, 1'b0, 1'b0, 15'h7FFF, 1'b0);
    step(1'b0, 15'h0, 1'b0, 16'h0);
    out("wr_pf", 1'b0, 16'h1111, 1'b0, 1'b1, 15'h0000, 1'b0);
    step(1'b0, 15'h0, 1'b1, 16'h2222);
    out("wr_pfack", 1'b0, 16'h1111, 1'b0, 1'b0, 15'h0000, 1'b0);
    step(1'b1, 15'h0000, 1'b0, 16'h0);
    out("wr_hit", 1'b1, 16'h2222, 1'b0, 1'b0, 15'h0000, 1'b0);
    step(1'b0, 15'h0, 1'b0, 16'h0);
    out("wr_pf2", 1'b0, 16'h2222, 1'b0, 1'b1, 15'h0001, 1'b0);
    step(1'b0, 15'h0, 1'b1, 16'h3333);
    out("wr_pf2ack", 1'b0, 16'h2222, 1'b0, 1'b0, 15'h0001, 1'b0);

    // Non-matching request while the prefetch of 0021 is outstanding.
    step(1'b1, 15'h0020, 1'b0, 16'h0);
    out("nm_req", 1'b0, 16'h2222, 1'b1, 1'b1, 15'h0020, 1'b0);
    step(1'b0, 15'h0, 1'b1, 16'h4444);
    out("nm_dlv", 1'b1, 16'h4444, 1'b0, 1'b0, 15'h0020, 1'b0);
    step(1'b0, 15'h0, 1'b0, 16'h0);
    out("nm_pf", 1'b0, 16'h4444, 1'b0, 1'b1, 15'h0021, 1'b0);
    step(1'b1, 15'h0100, 1'b0, 16'h0);
    out("nm_pend", 1'b0, 16'h4444, 1'b1, 1'b1, 15'h0021, 1'b0);
    step(1'b0, 15'h0, 1'b1, 16'h5555);
    out("nm_pfack", 1'b0, 16'h4444, 1'b1, 1'b0, 15'h0100, 1'b0);
    step(1'b0, 15'h0, 1'b0, 16'h0);
    out("nm_fetch", 1'b0, 16'h4444, 1'b1, 1'b1, 15'h0100, 1'b0);
    step(1'b0, 15'h0, 1'b1, 16'h6666);
    out("nm_dlv2", 1'b1, 16'h6666, 1'b0, 1'b0, 15'h0100, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch responder for the Hack CPU. Sits between the program counter and a multi-cycle instruction memory: it accepts a 15-bit fetch address from the PC, runs a request/acknowledge read cycle to memory, returns the 16-bit instruction with a one-cycle valid strobe, and asserts `stall` so the PC holds its value while a read is outstanding. An optional one-entry sequential prefetch buffer hides memory latency on straight-line code.

## Interface
- `TIMEOUT`, default 255: number of cycles to wait for `mem_ack` before aborting the read (range 1..65535).
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `pc_addr`  input  15  fetch address, taken from PC `out[14:0]`.
- `fetch_req`  input  1  request a fetch of `pc_addr`; sampled only when `stall` = 0.
- `instr`  output  16  fetched instruction; holds its value between deliveries.
- `instr_valid`  output  1  one-cycle pulse; `instr` is new this cycle.
- `stall`  output  1  fetch outstanding; the PC drives `inc` low and ignores `load` while this is high.
- `mem_addr`  output  15  memory read address (registered).
- `mem_rd`  output  1  memory read request (registered), level-held until acknowledged.
- `mem_rdata`  input  16  memory read data; valid when `mem_ack` = 1.
- `mem_ack`  input  1  memory acknowledge; ignored while `mem_rd` = 0.
- `timeout_err`  output  1  sticky; set on any read timeout; cleared only by reset.

## Operation
- States: IDLE, FETCH (demand read), PREFETCH (speculative read; present only with `PREFETCH_EN`).
- IDLE with `fetch_req` = 1:
  - Buffer miss: latch `pc_addr` into `mem_addr`, set `mem_rd` = 1, and go to FETCH.
  - Buffer hit (see Configuration): load `instr` from the buffer, pulse `instr_valid`, and stay in IDLE, or start a prefetch.
- FETCH: `mem_rd` is held at 1 with a stable `mem_addr`.
  - On `mem_ack`: drop `mem_rd`, capture `mem_rdata` into `instr`, and pulse `instr_valid`.
  - Then go to PREFETCH of `mem_addr`+1 when enabled, else to IDLE.
- Timeout: a counter clears on entry to FETCH or PREFETCH and increments each cycle without `mem_ack`.
  - When it reaches `TIMEOUT`, drop `mem_rd` and set `timeout_err`.
  - In FETCH, deliver `instr` = 16'h0000 with `instr_valid`, then go to IDLE.
  - In PREFETCH, invalidate the buffer and go to IDLE.
- `stall` = 1 exactly when in FETCH, or when in PREFETCH with a pending non-matching request (see Configuration). `stall` is registered.
- `fetch_req` while `stall` = 1 is ignored.
- Address arithmetic is 15-bit and wraps: 15'h7FFF + 1 = 15'h0000.
- `mem_ack` in IDLE, or in the cycle after `mem_rd` drops, is ignored. A late acknowledge after a timeout or reset is never delivered.

## Timing
- Reset (`reset_n` = 0 at a rising edge) applies the following next cycle, and aborts any read in progress:
  - `instr` = 16'h0000, `instr_valid` = 0, `stall` = 0, `mem_rd` = 0, `mem_addr` = 15'h0000, `timeout_err` = 0.
  - Buffer invalid, state IDLE.
- Miss latency, with the request in cycle 0:
  - `mem_rd`/`stall` rise in cycle 1.
  - If `mem_ack` is sampled in cycle k ≥ 1, then `instr_valid` is high in cycle k+1, with `mem_rd`/`stall` low in cycle k+1.
  - Minimum request-to-data latency is 2 cycles.
- Hit latency: `instr_valid` is high in cycle 1; `stall` never rises.
- `instr_valid` is never high for two consecutive cycles from the same request.

## Configuration
- `INSTR_FETCH_PREFETCH_EN` defined: after each demand delivery of address A, the block enters PREFETCH and reads A+1 into a one-entry buffer (data plus tag). `stall` = 0 during PREFETCH.
  - Request in PREFETCH with `pc_addr` equal to the prefetch tag: `stall` rises next cycle, and data is delivered on the prefetch ack (same latency as FETCH).
  - Request in PREFETCH with a non-matching `pc_addr`: the address is latched and `stall` rises. When the prefetch completes, its data is written to the buffer and FETCH of the latched address starts the next cycle.
  - Request in IDLE that matches a valid buffer tag: a hit; the next sequential prefetch starts.
  - The buffer is invalidated by reset or a prefetch timeout.
- Not defined: no buffer and no PREFETCH state; every request is a miss and the FSM returns to IDLE after delivery.

## Test plan
- Reset mid-FETCH: request 15'h0010, hold `mem_ack` = 0, pulse `reset_n` low → next cycle `mem_rd` = 0, `stall` = 0, `instr` = 0. A later `mem_ack` with 16'hBEEF produces no `instr_valid`.
- Zero-wait miss: request 15'h0005 with `mem_ack` returned in the first `mem_rd` cycle, `mem_rdata` = 16'h1234 → `instr_valid` exactly 2 cycles after the request, `instr` = 16'h1234, `mem_addr` = 15'h0005.
- Timeout with `TIMEOUT` = 4 and no ack → `mem_rd` high for 4 cycles, then `instr_valid` with `instr` = 16'h0000, and `timeout_err` = 1 until reset.
- Wrap (prefetch enabled): fetch 15'h7FFF → a prefetch is issued to 15'h0000. A request for 15'h0000 after the prefetch ack hits: `instr_valid` the next cycle with no `mem_rd`.
- Non-matching request during prefetch: fetch 15'h0020, then request 15'h0100 while the prefetch of 15'h0021 is pending → `stall` rises, 15'h0021 completes, then `mem_addr` = 15'h0100 and the correct data is delivered.
- Request ignored under stall: pulse `fetch_req` with 15'h0300 while in FETCH → exactly one delivery, for the original address.
